// File: rtl/recovery_pkg.sv
// Shared types and constants for the recovery register bank sequencer.
// The RECOVERY_VERIFY_EN build option adds the VERIFY state to the sequencer.
package recovery_pkg;

   localparam int NUM_REGS  = 32;
   localparam int DATA_W    = 32;
   localparam int FIRST_REG = 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SAVE    = 3'd1,
      RESTORE = 3'd2,
      DONE    = 3'd3,
      VERIFY  = 3'd4
   } state_t;

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/recovery_addr_counter.sv
// Loadable register-address walker shared by the SAVE, RESTORE and VERIFY passes.
// It saturates at the last address, so the walk never wraps back to x0.
module recovery_addr_counter #(
   parameter int NUM_REGS  = recovery_pkg::NUM_REGS,
   parameter int FIRST_REG = recovery_pkg::FIRST_REG
) (
   input  logic                                       clk,
   input  logic                                       rst_in,
   input  logic                                       load,
   input  logic                                       en,
   output logic [recovery_pkg::addr_w(NUM_REGS)-1:0]  cnt,
   output logic                                       last
);
   import recovery_pkg::*;

   localparam int            AW      = addr_w(NUM_REGS);
   localparam logic [AW-1:0] START_A = AW'(FIRST_REG);
   localparam logic [AW-1:0] LAST_A  = AW'(NUM_REGS - 1);

   assign last = (cnt == LAST_A);

   // NOTE: sequential state is updated with non-blocking assignments only, so every
   // flop samples the values from before the edge regardless of block ordering.
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in)
         cnt <= '0;
      else if (load)
         cnt <= START_A;
      else if (en && !last)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/recovery_sequencer.sv
// Checkpoint/rollback sequencer between the TMR voter, the core register file and
// the recovery register bank. Define RECOVERY_VERIFY_EN to add a read-back VERIFY pass.
module recovery_sequencer #(
   parameter int NUM_REGS  = recovery_pkg::NUM_REGS,
   parameter int DATA_W    = recovery_pkg::DATA_W,
   parameter int FIRST_REG = recovery_pkg::FIRST_REG
) (
   input  logic                                       clk,
   input  logic                                       rst_in,
   input  logic                                       ckpt_req,
   input  logic [31:0]                                ckpt_pc,
   input  logic                                       rollback_req,
   output logic [recovery_pkg::addr_w(NUM_REGS)-1:0]  rf_a,
   input  logic [DATA_W-1:0]                          rf_rd,
   output logic                                       rf_we,
   output logic [DATA_W-1:0]                          rf_wd,
   output logic [31:0]                                rec_a,
   input  logic [DATA_W-1:0]                          rec_rd,
   output logic                                       rec_we,
   output logic [DATA_W-1:0]                          rec_wd,
   output logic                                       core_stall,
   output logic [31:0]                                restore_pc,
   output logic                                       ckpt_valid,
   output logic                                       done,
   output logic                                       fail
);
   import recovery_pkg::*;

   localparam int AW = addr_w(NUM_REGS);

   state_t        state;
   logic [AW-1:0] cnt;
   logic          cnt_last;
   logic          cnt_load;
   logic          cnt_en;
   logic [31:0]   pc_shadow;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      cnt_load = 1'b0;
      if (state == IDLE)
         cnt_load = rollback_req ? ckpt_valid : ckpt_req;
`ifdef RECOVERY_VERIFY_EN
      if (state == SAVE && cnt_last && !rollback_req)
         cnt_load = 1'b1;
`endif
   end

   assign cnt_en = (state == SAVE) || (state == RESTORE) || (state == VERIFY);

   recovery_addr_counter #(
      .NUM_REGS  (NUM_REGS),
      .FIRST_REG (FIRST_REG)
   ) u_cnt (
      .clk    (clk),
      .rst_in (rst_in),
      .load   (cnt_load),
      .en     (cnt_en),
      .cnt    (cnt),
      .last   (cnt_last)
   );

   // A rollback arriving mid-save must suppress the bank write in that same cycle.
   assign rec_we = (state == SAVE) && !rollback_req;
   assign rf_we  = (state == RESTORE);
   assign rec_wd = rec_we ? rf_rd  : '0;
   assign rf_wd  = rf_we  ? rec_rd : '0;
   assign rf_a   = cnt;
   assign rec_a  = 32'(cnt);

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state      <= IDLE;
         core_stall <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         ckpt_valid <= 1'b0;
         restore_pc <= '0;
         pc_shadow  <= '0;
      end else begin
         done <= 1'b0;
         fail <= 1'b0;
         case (state)
            IDLE: begin
               if (rollback_req) begin
                  if (ckpt_valid) begin
                     state      <= RESTORE;
                     core_stall <= 1'b1;
                     restore_pc <= pc_shadow;
                  end else begin
                     fail <= 1'b1;
                  end
               end else if (ckpt_req) begin
                  state      <= SAVE;
                  core_stall <= 1'b1;
                  pc_shadow  <= ckpt_pc;
                  ckpt_valid <= 1'b0;
               end
            end
            SAVE: begin
               if (rollback_req) begin
                  state      <= IDLE;
                  core_stall <= 1'b0;
                  fail       <= 1'b1;
               end else if (cnt_last) begin
`ifdef RECOVERY_VERIFY_EN
                  state <= VERIFY;
`else
                  state <= DONE;
                  done  <= 1'b1;
`endif
               end
            end
`ifdef RECOVERY_VERIFY_EN
            VERIFY: begin
               if (rollback_req || (rf_rd != rec_rd)) begin
                  state      <= IDLE;
                  core_stall <= 1'b0;
                  fail       <= 1'b1;
               end else if (cnt_last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
`endif
            RESTORE: begin
               if (cnt_last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               // After a restore these already hold the same values, so no save/restore flag is kept.
               state      <= IDLE;
               core_stall <= 1'b0;
               ckpt_valid <= 1'b1;
               restore_pc <= pc_shadow;
            end
            default: begin
               state      <= IDLE;
               core_stall <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/recovery_sequencer.md
Name: recovery_sequencer

Overview:
Controller for the recovery register bank in the TMR RISC-V core. On a checkpoint request it stalls the core and copies the architectural register file into the recovery register bank, one entry per cycle, and latches the checkpoint PC. On a rollback request, raised by the TMR voter on a mismatch, it copies the recovery bank back into the register file and presents the restore PC. It sits between the voter/commit logic, the core register file and the recovery register bank.

Parameters:
NUM_REGS, 32, number of architectural registers; address counter width is clog2(NUM_REGS).
DATA_W, 32, register data width.
FIRST_REG, 1, first address copied; x0 is skipped because it is hardwired to zero.

Ports:
clk  in  1  clock, rising edge.
rst_in  in  1  asynchronous active-low reset.
ckpt_req  in  1  level request to checkpoint; sampled only in IDLE.
ckpt_pc  in  32  PC captured with the checkpoint, sampled on SAVE entry.
rollback_req  in  1  level request to restore.
rf_a  out  5  register file address.
rf_rd  in  DATA_W  register file read data, combinational from rf_a.
rf_we  out  1  register file write enable.
rf_wd  out  DATA_W  register file write data.
rec_a  out  32  recovery bank address, zero-extended counter.
rec_rd  in  DATA_W  recovery bank read data, combinational.
rec_we  out  1  recovery bank write enable.
rec_wd  out  DATA_W  recovery bank write data.
core_stall  out  1  freezes the pipeline while busy.
restore_pc  out  32  PC to redirect to after a restore.
ckpt_valid  out  1  recovery bank holds a complete checkpoint.
done  out  1  one-cycle pulse when a save or restore completes.
fail  out  1  one-cycle pulse when a save is aborted or a restore is refused.

Behaviour:
- Reset values (asynchronous, all zero): state=IDLE, counter=0, every output 0 including ckpt_valid and restore_pc.
- States: IDLE, SAVE, RESTORE, DONE.
- IDLE priority: rollback_req over ckpt_req.
  - rollback_req with ckpt_valid=1: go to RESTORE, counter=FIRST_REG.
  - rollback_req with ckpt_valid=0: fail pulse next cycle, stay in IDLE.
  - ckpt_req only: go to SAVE, counter=FIRST_REG, latch ckpt_pc into an internal pc_shadow, clear ckpt_valid.
- SAVE, one cycle per register:
  - Outputs: rf_a=cnt, rec_a=cnt, rec_we=1, rec_wd=rf_rd.
  - counter increments each cycle; at cnt=NUM_REGS-1 go to DONE.
  - Length is NUM_REGS-FIRST_REG cycles (31 by default).
- RESTORE, one cycle per register:
  - Outputs: rec_a=cnt, rf_a=cnt, rf_we=1, rf_wd=rec_rd.
  - Same length and exit rule as SAVE.
  - restore_pc=pc_shadow for the whole state and after it.
- DONE, one cycle:
  - done=1.
  - After a save: ckpt_valid=1, restore_pc<=pc_shadow.
  - Then return to IDLE.
  - Requests still asserted in DONE are ignored; they are re-sampled in IDLE on the next cycle.
- core_stall=1 in SAVE, RESTORE and DONE; 0 otherwise.
- Write enables are 0 outside SAVE/RESTORE; the same cycle never asserts both.
- rollback_req during SAVE: abort at once, with no write that cycle. Next cycle: fail=1, ckpt_valid=0, back to IDLE. The bank is partial and must not be restored.
- ckpt_req during SAVE or RESTORE is ignored.
- rollback_req during RESTORE is ignored.
- Counter never wraps: the exit check happens before the increment.
- Reset mid-operation: return to IDLE with ckpt_valid=0. Bank contents are untouched.

Optional Feature:
RECOVERY_VERIFY_EN
- Defined: adds a VERIFY state between SAVE and DONE.
  - Re-walks FIRST_REG..NUM_REGS-1 with rf_a=rec_a=cnt and no write enables, comparing rf_rd with rec_rd.
  - Any mismatch: fail pulse, ckpt_valid stays 0, go to IDLE.
  - All match: DONE.
  - Save latency doubles, to 62 cycles plus DONE.
  - rollback_req during VERIFY aborts exactly as in SAVE.
- Undefined: SAVE goes directly to DONE, and no compare logic is generated.

Decomposition:
- Shared package recovery_pkg:
  - state encoding typedef (IDLE=0, SAVE=1, RESTORE=2, DONE=3, VERIFY=4);
  - constants NUM_REGS, FIRST_REG, DATA_W;
  - address width function.
- One natural sub-module, recovery_addr_counter: a loadable up-counter with load, enable and last outputs, which is reused for SAVE, RESTORE and VERIFY.

Test Plan:
- Reset, then ckpt_req=1 with ckpt_pc=0x0000_0100 and rf[i]=i*0x11 → over 31 cycles rec_we=1 with rec_a=1..31; rec bank[5]=0x55; done pulses 1 cycle later; ckpt_valid=1; restore_pc=0x100; core_stall high for 32 cycles.
- After the save, corrupt rf[3]=0xDEADBEEF and assert rollback_req → rf_we for addresses 1..31; rf[3]=0x33; done pulses; restore_pc stays 0x100.
- rollback_req straight after reset → no writes; fail pulses once; state returns to IDLE.
- rollback_req at save cycle 10 (rec_a=10) → rec_we is 0 that cycle; fail pulses; ckpt_valid=0; a following rollback_req is refused with fail.
- ckpt_req and rollback_req together with ckpt_valid=1 → RESTORE is taken and no rec_we is asserted; rst_in pulled low mid-RESTORE → outputs return to 0 asynchronously and ckpt_valid=0.
- With RECOVERY_VERIFY_EN defined, force rf[7] to change during VERIFY → fail pulses, done does not, ckpt_valid=0.
